// File: rtl/local_flit_deserializer_pkg.sv
// Shared constants, field offsets and helpers for the router-local flit deserializer.
// Default geometry mirrors the top-level parameter defaults.
package local_flit_deserializer_pkg;

    localparam int DEF_PACKET_SIZE = 32;
    localparam int DEF_FLIT_SIZE   = 4;
    localparam int FLITS_PER_PKT   = DEF_PACKET_SIZE / DEF_FLIT_SIZE;

    // Spike packet field layout (bit offsets into pkt_data).
    localparam int AXON_LSB    = 0;
    localparam int Y_LSB       = 16;
    localparam int X_LSB       = 24;
    localparam int COORD_WIDTH = 8;

    typedef enum logic {
        ST_IDLE,
        ST_ASSEMBLE
    } asm_state_e;

    // $clog2 clamped to at least one bit so counters and pointers never collapse to zero width.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/local_flit_deserializer_fifo.sv
// Single-clock packet FIFO with a registered head (dout) and full/empty/count status.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module pkt_sync_fifo
    import local_flit_deserializer_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int PTR_W = clog2_min1(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_next;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_next = rd_ptr_q + PTR_W'(1);

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;

        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_next;

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // The head register tracks whichever entry will be at rd_ptr after this edge.
        if (do_pop) begin
            if (count_q > CNT_W'(1)) begin
                dout_d = mem_q[rd_next];
            end else if (do_push) begin
                dout_d = din;
            end
        end else if (do_push && empty) begin
            dout_d = din;
        end
    end

    // NOTE: the storage array is deliberately not reset; count/pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

    assign dout  = dout_q;
    assign count = count_q;

endmodule

// File: rtl/local_flit_deserializer.sv
// Router-local ejection stage: reassembles FLIT_SIZE-bit flits into PACKET_SIZE-bit packets,
// queues them in a packet FIFO and reports near-full back to the router.
module local_flit_deserializer
    import local_flit_deserializer_pkg::*;
#(
    parameter int PACKET_SIZE        = DEF_PACKET_SIZE,
    parameter int FLIT_SIZE          = DEF_FLIT_SIZE,
    parameter int FIFO_DEPTH         = 4,
    parameter int AXON_CNT_BIT_WIDTH = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [FLIT_SIZE-1:0]          flit_in,
    input  logic                          write_en,
    output logic                          neuron_full,
    output logic                          pkt_valid,
    input  logic                          pkt_ready,
    output logic [PACKET_SIZE-1:0]        pkt_data,
    output logic [AXON_CNT_BIT_WIDTH-1:0] pkt_axon,
    output logic                          overflow
);

    localparam int N_FLITS    = PACKET_SIZE / FLIT_SIZE;
    localparam int FCNT_W     = clog2_min1(N_FLITS);
    localparam int SHREG_W    = PACKET_SIZE - FLIT_SIZE;
    localparam int FIFO_CNT_W = clog2_min1(FIFO_DEPTH) + 1;

    asm_state_e              state_q, state_d;
    logic [FCNT_W-1:0]       fcnt_q, fcnt_d;
    logic [SHREG_W-1:0]      shreg_q, shreg_d;
    logic                    neuron_full_q, neuron_full_d;
    logic                    overflow_q, overflow_d;

    logic                    pkt_done;
    logic [PACKET_SIZE-1:0]  push_data;
    logic                    pop;
    logic                    push_ok;
    logic                    drop;
    logic [FIFO_CNT_W-1:0]   fifo_count;
    logic [FIFO_CNT_W-1:0]   count_next;
    logic                    fifo_full;
    logic                    fifo_empty;

    // Assembly FSM: the counter holds across write_en gaps; there is no timeout.
    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        shreg_d  = shreg_q;
        pkt_done = 1'b0;

        if (write_en) begin
            shreg_d = SHREG_W'({shreg_q, flit_in});
            case (state_q)
                ST_IDLE: begin
                    fcnt_d  = FCNT_W'(1);
                    state_d = ST_ASSEMBLE;
                end
                ST_ASSEMBLE: begin
                    if (fcnt_q == FCNT_W'(N_FLITS - 1)) begin
                        pkt_done = 1'b1;
                        fcnt_d   = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        fcnt_d = fcnt_q + FCNT_W'(1);
                    end
                end
                default: begin
                    fcnt_d  = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign push_data = {shreg_q, flit_in};
    assign pkt_valid = !fifo_empty;
    assign pop       = pkt_valid && pkt_ready;
    assign push_ok   = pkt_done && (!fifo_full || pop);
    assign drop      = pkt_done && fifo_full && !pop;

    // Occupancy after this edge; neuron_full keeps one slot of margin for the router's reaction delay.
    always_comb begin
        count_next = fifo_count;
        case ({push_ok, pop})
            2'b10:   count_next = fifo_count + FIFO_CNT_W'(1);
            2'b01:   count_next = fifo_count - FIFO_CNT_W'(1);
            default: count_next = fifo_count;
        endcase
        neuron_full_d = (count_next >= FIFO_CNT_W'(FIFO_DEPTH - 1));
        overflow_d    = overflow_q || drop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            fcnt_q        <= '0;
            shreg_q       <= '0;
            neuron_full_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            fcnt_q        <= fcnt_d;
            shreg_q       <= shreg_d;
            neuron_full_q <= neuron_full_d;
            overflow_q    <= overflow_d;
        end
    end

    pkt_sync_fifo #(
        .WIDTH (PACKET_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_pkt_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (pkt_done),
        .pop   (pop),
        .din   (push_data),
        .dout  (pkt_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign pkt_axon    = pkt_data[AXON_LSB +: AXON_CNT_BIT_WIDTH];
    assign neuron_full = neuron_full_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_local_flit_deserializer.sv
// Self-checking bench for local_flit_deserializer: table vectors, directed corner sequences
// and randomized traffic against a queue-based packet model.
module tb_local_flit_deserializer;

    localparam int PKT   = 32;
    localparam int FLIT  = 4;
    localparam int NFL   = PKT / FLIT;
    localparam int DEPTH = 4;

    logic            clk;
    logic            reset;
    logic [FLIT-1:0] flit_in;
    logic            write_en;
    logic            neuron_full;
    logic            pkt_valid;
    logic            pkt_ready;
    logic [PKT-1:0]  pkt_data;
    logic [0:0]      pkt_axon;
    logic            overflow;

    local_flit_deserializer #(
        .PACKET_SIZE        (PKT),
        .FLIT_SIZE          (FLIT),
        .FIFO_DEPTH         (DEPTH),
        .AXON_CNT_BIT_WIDTH (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flit_in     (flit_in),
        .write_en    (write_en),
        .neuron_full (neuron_full),
        .pkt_valid   (pkt_valid),
        .pkt_ready   (pkt_ready),
        .pkt_data    (pkt_data),
        .pkt_axon    (pkt_axon),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: packets are whole words in a queue; flits accumulate into a word.
    logic [PKT-1:0] m_q [$];
    logic [PKT-1:0] m_cur;
    int             m_nflits;
    logic           m_ovf;
    logic           m_full;
    int             m_delivered;

    typedef struct {
        logic            we;
        logic [FLIT-1:0] flit;
        logic            rdy;
        logic            exp_valid;
        logic [PKT-1:0]  exp_data;
    } vec_t;

    vec_t vecs [NFL + 1];

    task automatic check(input string name, input logic [PKT-1:0] act, input logic [PKT-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_cur    = '0;
        m_nflits = 0;
        m_ovf    = 1'b0;
        m_full   = 1'b0;
    endtask

    task automatic check_model();
        check("m_valid", 32'(pkt_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check("m_data", pkt_data, m_q[0]);
            check("m_axon", 32'(pkt_axon), 32'(m_q[0][0]));
        end
        check("m_full", 32'(neuron_full), 32'(m_full));
        check("m_ovf", 32'(overflow), 32'(m_ovf));
    endtask

    // One clock: drive inputs, advance the model across the edge, compare after the edge.
    task automatic cycle(input logic we, input logic [FLIT-1:0] f, input logic rdy);
        logic           pop_m;
        logic           push_m;
        logic [PKT-1:0] newp;
        write_en  = we;
        flit_in   = f;
        pkt_ready = rdy;
        pop_m     = rdy && (m_q.size() != 0);
        push_m    = 1'b0;
        newp      = '0;
        if (we) begin
            m_cur = {m_cur[PKT-FLIT-1:0], f};
            m_nflits++;
            if (m_nflits == NFL) begin
                push_m   = 1'b1;
                newp     = m_cur;
                m_nflits = 0;
            end
        end
        @(posedge clk);
        #1;
        if (pop_m) begin
            void'(m_q.pop_front());
            m_delivered++;
        end
        if (push_m) begin
            if (m_q.size() < DEPTH) m_q.push_back(newp);
            else m_ovf = 1'b1;
        end
        m_full = (m_q.size() >= DEPTH - 1);
        check_model();
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        write_en  = 1'b0;
        flit_in   = '0;
        pkt_ready = 1'b0;
        @(posedge clk);
        #1;
        check("rst_valid", 32'(pkt_valid), 32'd0);
        check("rst_full", 32'(neuron_full), 32'd0);
        check("rst_data", pkt_data, 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic send_pkt(input logic [PKT-1:0] p, input int gap, input logic rdy, input logic last_rdy);
        for (int i = 0; i < NFL; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) cycle(1'b0, '0, rdy);
            end
            cycle(1'b1, p[PKT-1-FLIT*i -: FLIT], (i == NFL - 1) ? last_rdy : rdy);
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1);
    endtask

    logic [PKT-1:0] pk [5];

    initial begin
        reset       = 1'b1;
        write_en    = 1'b0;
        flit_in     = '0;
        pkt_ready   = 1'b0;
        m_delivered = 0;
        model_clear();

        for (int i = 0; i < NFL; i++) begin
            vecs[i].we        = 1'b1;
            vecs[i].flit      = FLIT'(i + 1);
            vecs[i].rdy       = 1'b1;
            vecs[i].exp_valid = (i == NFL - 1);
            vecs[i].exp_data  = 32'h1234_5678;
        end
        vecs[NFL].we        = 1'b0;
        vecs[NFL].flit      = '0;
        vecs[NFL].rdy       = 1'b1;
        vecs[NFL].exp_valid = 1'b0;
        vecs[NFL].exp_data  = '0;

        pk[0] = 32'hDEAD_BEEF;
        pk[1] = 32'h0123_4567;
        pk[2] = 32'h89AB_CDEE;
        pk[3] = 32'hF0E1_D2C3;
        pk[4] = 32'h5A5A_A5A5;

        do_reset();

        // Back-to-back flits 1..8 with the consumer always ready.
        foreach (vecs[i]) begin
            cycle(vecs[i].we, vecs[i].flit, vecs[i].rdy);
            check("t1_valid", 32'(pkt_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                check("t1_data", pkt_data, vecs[i].exp_data);
                check("t1_axon", 32'(pkt_axon), 32'd0);
            end
        end

        // Same flits with 3-cycle gaps; nothing is valid until the 8th flit.
        for (int i = 0; i < NFL; i++) begin
            if (i > 0) begin
                for (int g = 0; g < 3; g++) begin
                    cycle(1'b0, '0, 1'b1);
                    check("t2_valid_low", 32'(pkt_valid), 32'd0);
                end
            end
            cycle(1'b1, FLIT'(i + 1), 1'b1);
            if (i < NFL - 1) check("t2_valid_low", 32'(pkt_valid), 32'd0);
        end
        check("t2_valid", 32'(pkt_valid), 32'd1);
        check("t2_data", pkt_data, 32'h1234_5678);
        drain(1);

        // Consumer stalled: near-full after 3 packets, 4th accepted, 5th dropped.
        do_reset();
        send_pkt(pk[0], 0, 1'b0, 1'b0);
        send_pkt(pk[1], 0, 1'b0, 1'b0);
        check("t3_full_after2", 32'(neuron_full), 32'd0);
        send_pkt(pk[2], 0, 1'b0, 1'b0);
        check("t3_full_after3", 32'(neuron_full), 32'd1);
        send_pkt(pk[3], 0, 1'b0, 1'b0);
        check("t3_ovf_after4", 32'(overflow), 32'd0);
        send_pkt(pk[4], 0, 1'b0, 1'b0);
        check("t3_ovf_after5", 32'(overflow), 32'd1);
        check("t3_head", pkt_data, pk[0]);
        drain(DEPTH + 1);
        check("t3_ovf_sticky", 32'(overflow), 32'd1);

        // Full FIFO, final flit coincides with a pop: both happen, no drop.
        do_reset();
        for (int i = 0; i < DEPTH; i++) send_pkt(pk[i], 0, 1'b0, 1'b0);
        check("t4_full", 32'(neuron_full), 32'd1);
        send_pkt(pk[4], 0, 1'b0, 1'b1);
        check("t4_ovf", 32'(overflow), 32'd0);
        check("t4_full_kept", 32'(neuron_full), 32'd1);
        check("t4_head", pkt_data, pk[1]);
        drain(DEPTH + 1);
        check("t4_empty", 32'(pkt_valid), 32'd0);

        // Reset mid-packet with two packets queued, then a clean reassembly.
        do_reset();
        send_pkt(pk[0], 0, 1'b0, 1'b0);
        send_pkt(pk[1], 0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, FLIT'(i + 9), 1'b0);
        do_reset();
        send_pkt(32'hAAAA_5555, 0, 1'b0, 1'b0);
        check("t5_valid", 32'(pkt_valid), 32'd1);
        check("t5_data", pkt_data, 32'hAAAA_5555);
        check("t5_axon", 32'(pkt_axon), 32'd1);
        drain(2);

        // Randomized traffic; the sender honours neuron_full so nothing may be dropped.
        do_reset();
        m_delivered = 0;
        for (int c = 0; c < 3000; c++) begin
            cycle(!neuron_full && ($urandom_range(0, 3) != 0),
                  FLIT'($urandom),
                  1'($urandom_range(0, 2) != 0 || (c % 97) > 80));
        end
        drain(DEPTH + 2);
        check("t6_no_drop", 32'(overflow), 32'd0);
        check("t6_delivered", 32'(m_delivered > 50), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
